// File: rtl/ncl_pkg.sv
// Shared dual-rail NULL Convention Logic types, constants and helpers.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
// Contents: dual-rail pair type, NULL/DATA0/DATA1 encodings, illegal-pair test.
package ncl_pkg;

   // One dual-rail bit, packed as {r1,r0}.
   typedef struct packed {
      logic r1;
      logic r0;
   } dr_t;

   localparam dr_t NCL_NULL = 2'b00;
   localparam dr_t NCL_D0   = 2'b01;
   localparam dr_t NCL_D1   = 2'b10;

   // Both rails high is not a valid wavefront.
   function automatic logic is_illegal(input dr_t x);
      return x.r1 & x.r0;
   endfunction

endpackage

// File: rtl/th_fadd_if.sv
// Dual-rail bus of the NCL full adder: three input pairs plus sum/carry pairs and status.
// Latency: n/a (wires only).
// Backpressure: none; NCL completion (done) replaces a ready signal.
// Ports: a0/a1, b0/b1, ci0/ci1 (operands), s0/s1, co0/co1 (results), done, err.
interface th_fadd_if;

   logic a0;
   logic a1;
   logic b0;
   logic b1;
   logic ci0;
   logic ci1;
   logic s0;
   logic s1;
   logic co0;
   logic co1;
   logic done;
   logic err;

   // Adder side: consumes operands, produces results.
   modport slave (
      input  a0, a1, b0, b1, ci0, ci1,
      output s0, s1, co0, co1, done, err
   );

   // Producer/observer side.
   modport master (
      output a0, a1, b0, b1, ci0, ci1,
      input  s0, s1, co0, co1, done, err
   );

endinterface

// File: rtl/th_fadd_th_gate.sv
// Generic registered threshold gate with hysteresis: sets when the weighted input sum reaches THRESH.
// Latency: 1 clk from input change to q_q; q_d is the same-cycle next state.
// Backpressure: none; the gate holds its state until the set or clear condition is met.
// Ports: clk, rst_n, in_vec (gate inputs), clr (return-to-NULL condition), q_d (next state), q_q (state).
module th_gate #(
   parameter int          N       = 3,
   parameter int          THRESH  = 2,
   // 4-bit weight per input, input i at WEIGHTS[4*i +: 4].
   parameter logic [4*N-1:0] WEIGHTS = {N{4'd1}}
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] in_vec,
   input  logic         clr,
   output logic         q_d,
   output logic         q_q
);

   logic [7:0] acc;

   always_comb begin
      acc = 8'd0;
      for (int i = 0; i < N; i++) begin
         if (in_vec[i]) begin
            acc = acc + {4'd0, WEIGHTS[4*i +: 4]};
         end
      end
      // Set wins over clear; otherwise the gate holds (hysteresis).
      q_d = q_q;
      if (acc >= 8'(THRESH)) begin
         q_d = 1'b1;
      end else if (clr) begin
         q_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q <= 1'b0;
      end else begin
         q_q <= q_d;
      end
   end

endmodule

// File: rtl/th_fadd.sv
// Dual-rail NCL full adder built from TH23 carry gates and TH34w2 sum gates, all registered.
// Latency: 1 clk from input wavefront to output wavefront; done/err registered alongside.
// Backpressure: none; done flags a complete DATA result, outputs return to NULL after an all-NULL input.
// Ports: clk, rst_n (async active-low), bus (th_fadd_if.slave: a/b/ci pairs in; s/co pairs, done, err out).
module th_fadd
   import ncl_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   th_fadd_if.slave     bus
);

   dr_t  a;
   dr_t  b;
   dr_t  ci;
   dr_t  s_d;
   dr_t  co_d;
   logic allnull;
   logic co0_d, co1_d, co0_q, co1_q;
   logic s0_d, s1_d, s0_q, s1_q;
   logic done_d, done_q;
   logic err_d, err_q;

   assign a  = {bus.a1, bus.a0};
   assign b  = {bus.b1, bus.b0};
   assign ci = {bus.ci1, bus.ci0};

   assign allnull = ~(|{a, b, ci});

   // Carry: 2-of-3 on each rail; early completion falls out of the threshold.
   th_gate #(.N(3), .THRESH(2), .WEIGHTS({4'd1, 4'd1, 4'd1})) u_co1 (
      .clk(clk), .rst_n(rst_n), .in_vec({a.r1, b.r1, ci.r1}),
      .clr(allnull), .q_d(co1_d), .q_q(co1_q)
   );

   th_gate #(.N(3), .THRESH(2), .WEIGHTS({4'd1, 4'd1, 4'd1})) u_co0 (
      .clk(clk), .rst_n(rst_n), .in_vec({a.r0, b.r0, ci.r0}),
      .clr(allnull), .q_d(co0_d), .q_q(co0_q)
   );

   // Sum: opposite carry counts double, so one agreeing input plus the
   // opposite carry (or all three inputs) reaches 3. Using the next carry
   // state keeps sum and carry landing on the same clock.
   th_gate #(.N(4), .THRESH(3), .WEIGHTS({4'd2, 4'd1, 4'd1, 4'd1})) u_s1 (
      .clk(clk), .rst_n(rst_n), .in_vec({co0_d, a.r1, b.r1, ci.r1}),
      .clr(allnull & ~co0_d), .q_d(s1_d), .q_q(s1_q)
   );

   th_gate #(.N(4), .THRESH(3), .WEIGHTS({4'd2, 4'd1, 4'd1, 4'd1})) u_s0 (
      .clk(clk), .rst_n(rst_n), .in_vec({co1_d, a.r0, b.r0, ci.r0}),
      .clr(allnull & ~co1_d), .q_d(s0_d), .q_q(s0_q)
   );

   always_comb begin
      s_d    = {s1_d, s0_d};
      co_d   = {co1_d, co0_d};
      done_d = (s_d != NCL_NULL) & (co_d != NCL_NULL);
      err_d  = is_illegal(a) | is_illegal(b) | is_illegal(ci);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         done_q <= done_d;
         err_q  <= err_d;
      end
   end

   assign bus.s0   = s0_q;
   assign bus.s1   = s1_q;
   assign bus.co0  = co0_q;
   assign bus.co1  = co1_q;
   assign bus.done = done_q;
   assign bus.err  = err_q;

endmodule

// File: tb/tb_th_fadd.sv
module tb_th_fadd;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   checks = 0;
   int   passed = 0;
   logic [5:0] obs;

   th_fadd_if bus();

   th_fadd dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // {s1,s0,co1,co0,done,err}
   assign obs = {bus.s1, bus.s0, bus.co1, bus.co0, bus.done, bus.err};

   // Rails ordered {a1,a0,b1,b0,ci1,ci0}.
   task automatic drive(input logic [5:0] r);
      {bus.a1, bus.a0, bus.b1, bus.b0, bus.ci1, bus.ci0} = r;
   endtask

   function automatic logic [5:0] dat(input logic a, input logic b, input logic c);
      return {a, ~a, b, ~b, c, ~c};
   endfunction

   // Expected settled outputs for a complete DATA wavefront.
   function automatic logic [5:0] exp_data(input logic a, input logic b, input logic c);
      logic s, y;
      s = a ^ b ^ c;
      y = (a & b) | (a & c) | (b & c);
      return {s, ~s, y, ~y, 1'b1, 1'b0};
   endfunction

   task automatic go_null(input int n);
      @(negedge clk);
      drive(6'b0);
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset;
      #1;
      rst_n = 1'b0;
      drive(dat(1'b1, 1'b1, 1'b1));
      #1;
      checks++; if (obs !== 6'b0) $display("FAIL reset_async: got %b want %b", obs, 6'b0); else passed++;
      repeat (3) @(negedge clk);
      checks++; if (obs !== 6'b0) $display("FAIL reset_hold: got %b want %b", obs, 6'b0); else passed++;
      drive(6'b0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (obs !== 6'b0) $display("FAIL reset_release_null: got %b want %b", obs, 6'b0); else passed++;
   endtask

   task automatic test_exhaustive;
      for (int v = 0; v < 8; v++) begin
         logic [2:0] abc;
         abc = v[2:0];
         go_null(3);
         checks++; if (obs !== 6'b0) $display("FAIL exh_null v=%0d: got %b want %b", v, obs, 6'b0); else passed++;
         drive(dat(abc[2], abc[1], abc[0]));
         @(negedge clk);
         checks++;
         if (obs !== exp_data(abc[2], abc[1], abc[0]))
            $display("FAIL exh_data v=%0d: got %b want %b", v, obs, exp_data(abc[2], abc[1], abc[0]));
         else passed++;
      end
   endtask

   task automatic test_stagger;
      go_null(3);
      // a still NULL, b=0, ci=0: carry-out 0 completes early, sum must wait.
      drive(6'b00_01_01);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++; if (obs !== 6'b000100) $display("FAIL stagger_early cyc=%0d: got %b want %b", i, obs, 6'b000100); else passed++;
      end
      drive(6'b10_01_01);
      @(negedge clk);
      checks++; if (obs !== 6'b100110) $display("FAIL stagger_final: got %b want %b", obs, 6'b100110); else passed++;
   endtask

   task automatic test_hysteresis;
      go_null(3);
      drive(dat(1'b1, 1'b1, 1'b1));
      @(negedge clk);
      checks++; if (obs !== 6'b101010) $display("FAIL hyst_data: got %b want %b", obs, 6'b101010); else passed++;
      drive(6'b00_10_10);
      repeat (2) @(negedge clk);
      checks++; if (obs !== 6'b101010) $display("FAIL hyst_partial_null: got %b want %b", obs, 6'b101010); else passed++;
      drive(6'b00_00_10);
      @(negedge clk);
      checks++; if (obs !== 6'b101010) $display("FAIL hyst_one_left: got %b want %b", obs, 6'b101010); else passed++;
      drive(6'b0);
      @(negedge clk);
      checks++; if (obs !== 6'b0) $display("FAIL hyst_all_null: got %b want %b", obs, 6'b0); else passed++;
   endtask

   task automatic test_illegal;
      go_null(3);
      drive(6'b11_00_00);
      @(negedge clk);
      checks++; if (obs !== 6'b000001) $display("FAIL illegal_set: got %b want %b", obs, 6'b000001); else passed++;
      drive(6'b0);
      @(negedge clk);
      checks++; if (obs !== 6'b0) $display("FAIL illegal_clear: got %b want %b", obs, 6'b0); else passed++;
   endtask

   task automatic test_reset_mid;
      go_null(3);
      drive(dat(1'b1, 1'b1, 1'b1));
      @(negedge clk);
      checks++; if (obs !== 6'b101010) $display("FAIL rstmid_pre: got %b want %b", obs, 6'b101010); else passed++;
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (obs !== 6'b0) $display("FAIL rstmid_async: got %b want %b", obs, 6'b0); else passed++;
      @(negedge clk);
      rst_n = 1'b1;
      drive(6'b0);
      repeat (2) @(negedge clk);
      checks++; if (obs !== 6'b0) $display("FAIL rstmid_null: got %b want %b", obs, 6'b0); else passed++;
      drive(dat(1'b1, 1'b0, 1'b1));
      @(negedge clk);
      checks++; if (obs !== 6'b011010) $display("FAIL rstmid_data5: got %b want %b", obs, 6'b011010); else passed++;
   endtask

   initial begin
      drive(6'b0);
      test_reset;
      test_exhaustive;
      test_stagger;
      test_hysteresis;
      test_illegal;
      test_reset_mid;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
